// File: rtl/spi_md5_pkg.sv
// Shared constants, fill FSM state type and index-width helper
// for the SPI-to-MD5 block framing path.
package spi_md5_pkg;

  localparam int BLOCK_BYTES_DEF  = 64;
  localparam int IDLE_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } fill_state_e;

  // Byte index width; at least one bit even for tiny blocks.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_block_framer_if.sv
// Block handshake bundle: block_data/block_valid out, block_ready in,
// plus block_xsum when SPI_FRAMER_XSUM_EN is defined.
interface spi_block_framer_if
  import spi_md5_pkg::*;
#(
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF
);

  logic [8*BLOCK_BYTES-1:0] block_data;
  logic                     block_valid;
  logic                     block_ready;
`ifdef SPI_FRAMER_XSUM_EN
  logic [7:0]               block_xsum;

  modport master (
    output block_data,
    output block_valid,
    output block_xsum,
    input  block_ready
  );

  modport slave (
    input  block_data,
    input  block_valid,
    input  block_xsum,
    output block_ready
  );
`else
  modport master (
    output block_data,
    output block_valid,
    input  block_ready
  );

  modport slave (
    input  block_data,
    input  block_valid,
    output block_ready
  );
`endif

endinterface

// File: rtl/spi_idle_timer.sv
// Saturating count of consecutive sel-low edges.
// Ports: clk, reset, sel, clr (restart), timeout (pulse, comb).
module spi_idle_timer #(
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sel,
  input  logic clr,
  output logic timeout
);

  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(IDLE_TIMEOUT - 1);
  localparam logic [CW-1:0] SAT  = CW'(IDLE_TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sel || clr) begin
      cnt_d = '0;
    end else if (cnt_q != SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // High in the cycle whose edge brings the count to IDLE_TIMEOUT;
  // saturation keeps it from firing again until sel returns.
  assign timeout = !sel && !clr && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_block_framer.sv
// Assembles SPI bytes into BLOCK_BYTES-byte blocks for the MD5 core.
// Ports: clk, reset, sel, buffer, blk (master), abort, overflow.
// Option SPI_FRAMER_XSUM_EN adds blk.block_xsum (XOR of block bytes).
module spi_block_framer
  import spi_md5_pkg::*;
#(
  parameter int BLOCK_BYTES  = BLOCK_BYTES_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sel,
  input  logic [7:0]                buffer,
  spi_block_framer_if.master        blk,
  output logic                      abort,
  output logic                      overflow
);

  localparam int IW = idx_w(BLOCK_BYTES);
  localparam int DW = 8 * BLOCK_BYTES;
  localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_BYTES - 1);

  fill_state_e   state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          byte_done_q, byte_done_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          abort_q, abort_d;
  logic          overflow_q, overflow_d;

  logic timeout;
  logic accept;
  logic out_free;
  logic last_idx;
  logic partial;
  logic capture;
  logic xfer_fill;
  logic xfer_full;
  logic xfer;
  logic tmo_fill;

  spi_idle_timer #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .clr    (byte_done_q),
    .timeout(timeout)
  );

  assign accept   = out_valid_q && blk.block_ready;
  assign out_free = !out_valid_q || blk.block_ready;
  assign last_idx = (idx_q == LAST_IDX);
  assign partial  = (bit_cnt_q != 3'd0) || (idx_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (sel) state_d = FILL;
      end
      FILL: begin
        if (byte_done_q) begin
          if (last_idx) begin
            state_d = out_free ? IDLE : FULL;
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      FULL: begin
        if (accept) begin
          state_d = (bit_cnt_q != 3'd0) ? FILL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture    = (state_q == FILL) && byte_done_q;
    xfer_fill  = capture && last_idx && out_free;
    xfer_full  = (state_q == FULL) && accept;
    xfer       = xfer_fill || xfer_full;
    // Timer already yields to a capture, so no byte_done term here.
    tmo_fill   = (state_q == FILL) && timeout;
    abort_d    = tmo_fill && partial;
    overflow_d = (state_q == FULL) && byte_done_q;
  end

  always_comb begin
    byte_done_d = sel && (bit_cnt_q == 3'd7);

    bit_cnt_d = bit_cnt_q;
    if (timeout) begin
      bit_cnt_d = 3'd0;
    end else if (sel) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    fill_d = fill_q;
    if (capture) begin
      fill_d[int'(idx_q)*8 +: 8] = buffer;
    end

    // Index holds at the last slot while FULL.
    idx_d = idx_q;
    if (xfer) begin
      idx_d = '0;
    end else if (capture && !last_idx) begin
      idx_d = idx_q + 1'b1;
    end else if (tmo_fill) begin
      idx_d = '0;
    end

    // Same-cycle capture of the last byte goes straight to the output.
    out_data_d  = xfer ? fill_d : out_data_q;
    out_valid_d = xfer || (out_valid_q && !accept);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      idx_q       <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      abort_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      abort_q     <= abort_d;
      overflow_q  <= overflow_d;
    end
  end

  assign blk.block_data  = out_data_q;
  assign blk.block_valid = out_valid_q;
  assign abort           = abort_q;
  assign overflow        = overflow_q;

`ifdef SPI_FRAMER_XSUM_EN
  logic [7:0] acc_q, acc_d;
  logic [7:0] acc_cap;
  logic [7:0] out_xsum_q, out_xsum_d;

  always_comb begin
    acc_cap    = capture ? (acc_q ^ buffer) : acc_q;
    acc_d      = (xfer || tmo_fill) ? 8'h00 : acc_cap;
    out_xsum_d = xfer ? acc_cap : out_xsum_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= 8'h00;
      out_xsum_q <= 8'h00;
    end else begin
      acc_q      <= acc_d;
      out_xsum_q <= out_xsum_d;
    end
  end

  assign blk.block_xsum = out_xsum_q;
`endif

endmodule

// File: tb/tb_spi_block_framer.sv
// Directed bench for spi_block_framer with a bit-level SPI
// shift register model driving buffer.
module tb_spi_block_framer;

  localparam int BB = 64;
  localparam int TO = 16;
  localparam int DW = 8 * BB;

  logic       clk;
  logic       reset;
  logic       sel;
  logic       bit_in;
  logic [7:0] sh;
  logic       abort;
  logic       overflow;

  int errors;
  int checks;
  int ovf_cnt;
  int abt_cnt;
  int stab_err;

  logic          prev_v;
  logic          prev_r;
  logic [DW-1:0] prev_d;

  spi_block_framer_if #(.BLOCK_BYTES(BB)) blk ();

  spi_block_framer #(
    .BLOCK_BYTES (BB),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .buffer  (sh),
    .blk     (blk),
    .abort   (abort),
    .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (sel) sh <= {sh[6:0], bit_in};
  end

  initial begin
    ovf_cnt  = 0;
    abt_cnt  = 0;
    stab_err = 0;
    prev_v   = 1'b0;
    prev_r   = 1'b0;
    prev_d   = '0;
  end

  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
    if (abort) abt_cnt++;
    if (prev_v && !prev_r && blk.block_valid && blk.block_data != prev_d)
      stab_err++;
    prev_v = blk.block_valid;
    prev_r = blk.block_ready;
    prev_d = blk.block_data;
  end

  function automatic logic [DW-1:0] mk(input logic [7:0] base,
                                       input logic [7:0] mult);
    logic [DW-1:0] r;
    logic [7:0] b;
    r = '0;
    for (int i = 0; i < BB; i++) begin
      b = base + mult * 8'(i);
      r[i*8 +: 8] = b;
    end
    return r;
  endfunction

  function automatic logic [7:0] xs(input logic [DW-1:0] v);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < BB; i++) x = x ^ v[i*8 +: 8];
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sel    = 1'b1;
    bit_in = b;
    step();
  endtask

  task automatic idle(input int n);
    sel = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_vec(input logic [DW-1:0] v);
    for (int i = 0; i < BB; i++) send_byte(v[i*8 +: 8]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sel   = 1'b0;
    bit_in = 1'b0;
    blk.block_ready = 1'b0;
    step();
    step();
    checks++;
    if (blk.block_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b want 0", blk.block_valid);
    end
    checks++;
    if (blk.block_data !== '0) begin
      errors++;
      $display("FAIL rst_data: got %h want 0", blk.block_data);
    end
    checks++;
    if (abort !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulses: got abort=%b ovf=%b want 0 0",
               abort, overflow);
    end
`ifdef SPI_FRAMER_XSUM_EN
    checks++;
    if (blk.block_xsum !== 8'h00) begin
      errors++;
      $display("FAIL rst_xsum: got %h want 00", blk.block_xsum);
    end
`endif
    reset = 1'b0;
    step();
  endtask

  task automatic test_stream();
    logic [DW-1:0] e;
    e = mk(8'h00, 8'h01);
    blk.block_ready = 1'b1;
    send_vec(e);
    checks++;
    if (blk.block_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_early: got %b want 0", blk.block_valid);
    end
    idle(1);
    checks++;
    if (blk.block_valid !== 1'b1) begin
      errors++;
      $display("FAIL stream_valid: got %b want 1", blk.block_valid);
    end
    checks++;
    if (blk.block_data[7:0] !== 8'h00) begin
      errors++;
      $display("FAIL stream_b0: got %h want 00", blk.block_data[7:0]);
    end
    checks++;
    if (blk.block_data[511:504] !== 8'h3F) begin
      errors++;
      $display("FAIL stream_b63: got %h want 3f",
               blk.block_data[511:504]);
    end
    checks++;
    if (blk.block_data !== e) begin
      errors++;
      $display("FAIL stream_data: got %h want %h", blk.block_data, e);
    end
`ifdef SPI_FRAMER_XSUM_EN
    checks++;
    if (blk.block_xsum !== 8'h00) begin
      errors++;
      $display("FAIL stream_xsum: got %h want 00", blk.block_xsum);
    end
`endif
    idle(1);
    checks++;
    if (blk.block_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_pulse: got %b want 0", blk.block_valid);
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] e;
    int n;
    int first;
    int vseen;
    n = 0;
    first = -1;
    vseen = 0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int k = 1; k <= 20; k++) begin
      idle(1);
      if (abort) begin
        n++;
        if (first < 0) first = k;
      end
      if (blk.block_valid) vseen++;
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL abort_count: got %0d want 1", n);
    end
    checks++;
    if (first !== TO) begin
      errors++;
      $display("FAIL abort_cycle: got %0d want %0d", first, TO);
    end
    checks++;
    if (vseen !== 0) begin
      errors++;
      $display("FAIL abort_novalid: got %0d want 0", vseen);
    end
    e = mk(8'hA5, 8'h00);
    send_vec(e);
    idle(1);
    checks++;
    if (blk.block_valid !== 1'b1 || blk.block_data !== e) begin
      errors++;
      $display("FAIL abort_next: got v=%b %h want 1 %h",
               blk.block_valid, blk.block_data, e);
    end
`ifdef SPI_FRAMER_XSUM_EN
    checks++;
    if (blk.block_xsum !== 8'h00) begin
      errors++;
      $display("FAIL abort_xsum: got %h want 00", blk.block_xsum);
    end
`endif
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    int o0;
    e1 = mk(8'h40, 8'h01);
    e2 = mk(8'h07, 8'h0D);
    blk.block_ready = 1'b0;
    o0 = ovf_cnt;
    send_vec(e1);
    send_vec(e2);
    send_byte(8'hEE);
    idle(3);
    checks++;
    if (ovf_cnt - o0 !== 1) begin
      errors++;
      $display("FAIL bp_overflow: got %0d want 1", ovf_cnt - o0);
    end
    idle(20);
    checks++;
    if (blk.block_valid !== 1'b1 || blk.block_data !== e1) begin
      errors++;
      $display("FAIL bp_hold1: got v=%b %h want 1 %h",
               blk.block_valid, blk.block_data, e1);
    end
    checks++;
    if (ovf_cnt - o0 !== 1) begin
      errors++;
      $display("FAIL bp_ovf_once: got %0d want 1", ovf_cnt - o0);
    end
    blk.block_ready = 1'b1;
    step();
    checks++;
    if (blk.block_valid !== 1'b1 || blk.block_data !== e2) begin
      errors++;
      $display("FAIL bp_block2: got v=%b %h want 1 %h",
               blk.block_valid, blk.block_data, e2);
    end
`ifdef SPI_FRAMER_XSUM_EN
    checks++;
    if (blk.block_xsum !== xs(e2)) begin
      errors++;
      $display("FAIL bp_xsum2: got %h want %h", blk.block_xsum, xs(e2));
    end
`endif
    step();
    checks++;
    if (blk.block_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got %b want 0", blk.block_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    int o0;
    ea = mk(8'hFF, 8'hFF);
    eb = mk(8'h03, 8'h03);
    blk.block_ready = 1'b0;
    o0 = ovf_cnt;
    send_vec(ea);
    send_vec(eb);
    checks++;
    if (blk.block_valid !== 1'b1 || blk.block_data !== ea) begin
      errors++;
      $display("FAIL b2b_a: got v=%b %h want 1 %h",
               blk.block_valid, blk.block_data, ea);
    end
    blk.block_ready = 1'b1;
    idle(1);
    checks++;
    if (blk.block_valid !== 1'b1 || blk.block_data !== eb) begin
      errors++;
      $display("FAIL b2b_b: got v=%b %h want 1 %h",
               blk.block_valid, blk.block_data, eb);
    end
`ifdef SPI_FRAMER_XSUM_EN
    checks++;
    if (blk.block_xsum !== xs(eb)) begin
      errors++;
      $display("FAIL b2b_xsum: got %h want %h", blk.block_xsum, xs(eb));
    end
`endif
    idle(1);
    checks++;
    if (blk.block_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got %b want 0", blk.block_valid);
    end
    checks++;
    if (ovf_cnt - o0 !== 0) begin
      errors++;
      $display("FAIL b2b_noovf: got %0d want 0", ovf_cnt - o0);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    e1 = mk(8'h11, 8'h01);
    e2 = mk(8'h40, 8'h05);
    blk.block_ready = 1'b0;
    send_vec(e1);
    for (int i = 0; i < 29; i++) send_byte(8'h5C);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    sel   = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (blk.block_valid !== 1'b0 || blk.block_data !== '0) begin
      errors++;
      $display("FAIL rmid_out: got v=%b %h want 0 0",
               blk.block_valid, blk.block_data);
    end
    checks++;
    if (abort !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rmid_pulses: got abort=%b ovf=%b want 0 0",
               abort, overflow);
    end
    blk.block_ready = 1'b1;
    send_vec(e2);
    idle(1);
    checks++;
    if (blk.block_data[7:0] !== 8'h40) begin
      errors++;
      $display("FAIL rmid_b0: got %h want 40", blk.block_data[7:0]);
    end
    checks++;
    if (blk.block_valid !== 1'b1 || blk.block_data !== e2) begin
      errors++;
      $display("FAIL rmid_block: got v=%b %h want 1 %h",
               blk.block_valid, blk.block_data, e2);
    end
    idle(2);
  endtask

  task automatic test_slow_bits();
    logic [DW-1:0] e;
    logic [7:0] b;
    int a0;
    e = mk(8'h20, 8'h01);
    e[7:0] = 8'h96;
    b = 8'h96;
    a0 = abt_cnt;
    blk.block_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      idle(TO - 1);
    end
    for (int i = 1; i < BB; i++) send_byte(e[i*8 +: 8]);
    idle(1);
    checks++;
    if (blk.block_valid !== 1'b1 || blk.block_data !== e) begin
      errors++;
      $display("FAIL slow_block: got v=%b %h want 1 %h",
               blk.block_valid, blk.block_data, e);
    end
    checks++;
    if (abt_cnt - a0 !== 0) begin
      errors++;
      $display("FAIL slow_noabort: got %0d want 0", abt_cnt - a0);
    end
    idle(2);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_stream();
    test_abort();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_slow_bits();
    checks++;
    if (stab_err !== 0) begin
      errors++;
      $display("FAIL data_stable: got %0d changes want 0", stab_err);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
